secded_codec_pipe: RTL and testbench
====================================

// Module: secded_codec_pipe
// PURPOSE
//  Parametrised, pipelined Hamming SECDED encoder/decoder; per-transaction mode (encode or decode).
//  Generalises the fixed 11-bit single-cycle parity/packing ALU ops to any DATA_W.
//  Adds valid/ready flow control, 2-stage pipeline and saturating error-statistics counters.
//  Sits beside the ALU as a co-processor fed from the register file or a streaming source.
// PARAMETERS
//  DATA_W   11  payload bits, legal range 4..57.
//  CNT_W    16  width of each error counter.
//  PAR_W    derived localparam: smallest r with 2**r >= DATA_W+r+1 (4 for DATA_W=11).
//  CODE_W   derived localparam: DATA_W+PAR_W+1 (16 for DATA_W=11).
// PORTS
//  clk           in   1       clock, rising edge
//  rst_n         in   1       asynchronous, active-low reset
//  in_valid      in   1       input transaction present
//  in_ready      out  1       block accepts input this cycle
//  in_mode       in   1       0 = encode, 1 = decode
//  in_word       in   CODE_W  encode: payload in [DATA_W-1:0], upper bits ignored; decode: codeword
//  out_valid     out  1       result present
//  out_ready     in   1       sink accepts result this cycle
//  out_mode      out  1       mode of the presented result
//  out_word      out  CODE_W  encode: codeword; decode: corrected payload, zero-extended
//  out_status    out  2       00 clean, 01 single corrected, 10 uncorrectable, 11 unused; 00 in encode
//  out_syndrome  out  PAR_W   decode syndrome; 0 in encode
//  clr_cnt       in   1       synchronous clear of both counters
//  corr_cnt      out  CNT_W   accepted decodes with status 01, saturating
//  uncorr_cnt    out  CNT_W   accepted decodes with status 10, saturating
// BEHAVIOUR
//  Reset: in_ready=1 after reset; out_valid=0; all other outputs and counters 0.
//  Reset discards in-flight transactions; no partial results are emitted.
//  Codeword layout: bit 0 = p0, an overall even parity over bits CODE_W-1..0.
//  Positions 1,2,4,8,... carry Hamming parity p(2^j).
//  Payload bit k occupies the k-th non-power-of-two position, counting upward from position 3.
//  p(2^j) makes the XOR of all positions i>=1 with bit j of i set equal to 0.
//  Decode: S = XOR of indices i (1..CODE_W-1) whose bit is 1. P = XOR of all CODE_W bits.
//   S==0, P==0: status 00.
//   P==1, S<CODE_W: flip bit S (S==0 flips p0); status 01.
//   P==1, S>=CODE_W: status 10, payload passed uncorrected.
//   S!=0, P==0: double error; status 10, payload passed uncorrected.
//  Pipeline: stage 1 registers the mode, the word, S and P (or the computed parities).
//  Stage 2 registers the final out_* values. Latency is 2 cycles from in handshake to out_valid.
//  Throughput is 1 per cycle with out_ready held high.
//  Flow control: each stage loads when it is empty or its contents leave in the same cycle.
//   in_ready = ~s1_valid | (~s2_valid | out_ready).
//   in_ready never depends combinationally on in_valid.
//  Hold: while out_valid & ~out_ready, all out_* signals stay stable.
//  Capacity is 2 transactions, with no loss and no reordering.
//  Counters: update only on out_valid & out_ready with out_mode=1; saturate at 2**CNT_W-1.
//  If clr_cnt and an increment occur in the same cycle, clr_cnt wins and the counter becomes 0.
// TESTING (DATA_W=11, CNT_W=2 where noted)
//  Encode 11'h000 -> out_word 16'h0000, status 00, 2 cycles after accept.
//  Encode 11'h7FF -> 16'hFFFF; back-to-back encode+decode of 16'hFFFF -> 7FF, status 00, consecutive cycles.
//  Decode 16'hFFBF (bit 6 flipped) -> 11'h7FF, status 01, syndrome 6; corr_cnt +1.
//  Decode 16'hFFFE (p0 flipped) -> 11'h7FF, status 01, syndrome 0.
//  Decode 16'hFFFC (bits 0,1 flipped) -> status 10, syndrome 1; uncorr_cnt +1.
//  Hold out_ready=0 and offer 3 inputs: in_ready drops after 2 accepts.
//  Release out_ready: 3 results emerge in order with none lost.
//  CNT_W=2: 5 corrected decodes -> corr_cnt=3.
//  clr_cnt together with an accepted status-01 result -> 0.
//  Assert rst_n low mid-stream -> out_valid=0 and counters 0 immediately (asynchronous).

Source files
------------

// File: rtl/secded_codec_pipe.sv
// Pipelined Hamming SECDED encoder/decoder with a selectable mode for each transaction.
// It has two register stages with valid/ready flow control and saturating counters for corrected and uncorrectable errors.
module secded_codec_pipe #(
  parameter int DATA_W = 11,
  parameter int CNT_W = 16,
  localparam int PAR_W = (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 : (DATA_W <= 26) ? 5 : 6,
  localparam int CODE_W = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [CODE_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_mode,
  output logic [CODE_W-1:0] out_word,
  output logic [1:0]        out_status,
  output logic [PAR_W-1:0]  out_syndrome,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  localparam logic [1:0] ST_CLEAN  = 2'b00;
  localparam logic [1:0] ST_CORR   = 2'b01;
  localparam logic [1:0] ST_UNCORR = 2'b10;

  logic              s1_valid;
  logic              s1_mode;
  logic [CODE_W-1:0] s1_word;
  logic [PAR_W-1:0]  s1_syn;
  logic              s1_par;
  logic              s1_load;
  logic              s2_load;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // Each stage loads when it is empty or its contents are leaving. Ready never looks at valid.
  assign s2_load  = ~out_valid | out_ready;
  assign s1_load  = ~s1_valid | s2_load;
  assign in_ready = s1_load;

  logic [CODE_W-1:0] enc_word;
  logic [PAR_W-1:0]  dec_syn;
  logic              dec_par;

  always_comb begin
    int k;
    logic par;
    enc_word = '0;
    k = 0;
    par = 1'b0;
    for (int i = 1; i < CODE_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        enc_word[i] = in_word[k];
        k = k + 1;
      end
    end
    // Parity positions carry only bit j of their own index, so they do not disturb one another.
    for (int j = 0; j < PAR_W; j++) begin
      par = 1'b0;
      for (int i = 1; i < CODE_W; i++) begin
        if (((i >> j) & 1) == 1) par = par ^ enc_word[i];
      end
      enc_word[1 << j] = par;
    end
    enc_word[0] = ^enc_word;
  end

  always_comb begin
    dec_syn = '0;
    for (int i = 1; i < CODE_W; i++) begin
      if (in_word[i]) dec_syn = dec_syn ^ i[PAR_W-1:0];
    end
    dec_par = ^in_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_word  <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode <= in_mode;
        s1_word <= in_mode ? in_word : enc_word;
        s1_syn  <= in_mode ? dec_syn : '0;
        s1_par  <= in_mode ? dec_par : 1'b0;
      end
    end
  end

  logic [CODE_W-1:0] fix_word;
  logic [CODE_W-1:0] dec_data;
  logic [1:0]        nxt_status;

  always_comb begin
    int k;
    fix_word   = s1_word;
    nxt_status = ST_CLEAN;
    dec_data   = '0;
    k = 0;
    if (s1_mode) begin
      if (s1_par) begin
        if (int'(s1_syn) < CODE_W) begin
          for (int i = 0; i < CODE_W; i++) begin
            if (int'(s1_syn) == i) fix_word[i] = ~s1_word[i];
          end
          nxt_status = ST_CORR;
        end else begin
          nxt_status = ST_UNCORR;
        end
      end else if (s1_syn != '0) begin
        nxt_status = ST_UNCORR;
      end
    end
    for (int i = 1; i < CODE_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        dec_data[k] = fix_word[i];
        k = k + 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_mode     <= 1'b0;
      out_word     <= '0;
      out_status   <= ST_CLEAN;
      out_syndrome <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_mode     <= s1_mode;
        out_word     <= s1_mode ? dec_data : s1_word;
        out_status   <= nxt_status;
        out_syndrome <= s1_syn;
      end
    end
  end

  logic fire_dec;
  assign fire_dec = out_valid & out_ready & out_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (clr_cnt) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (fire_dec) begin
      if (out_status == ST_CORR && corr_cnt != {CNT_W{1'b1}})
        corr_cnt <= corr_cnt + 1'b1;
      if (out_status == ST_UNCORR && uncorr_cnt != {CNT_W{1'b1}})
        uncorr_cnt <= uncorr_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_secded_codec_pipe.sv
// Bench for secded_codec_pipe with DATA_W=11 and CNT_W=2. It applies table vectors, hand-written flow-control and counter sequences,
// and random traffic, all checked by a scoreboard that is fed from a syndrome-based reference model.
module tb_secded_codec_pipe;

  localparam int DW = 11;
  localparam int CW = 16;
  localparam int PW = 4;
  localparam int REC_W = 1 + CW + 2 + PW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_mode = 1'b0;
  logic [CW-1:0] in_word = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_mode;
  logic [CW-1:0] out_word;
  logic [1:0]    out_status;
  logic [PW-1:0] out_syndrome;
  logic          clr_cnt = 1'b0;
  logic [1:0]    corr_cnt;
  logic [1:0]    uncorr_cnt;

  secded_codec_pipe #(.DATA_W(DW), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode), .out_word(out_word),
    .out_status(out_status), .out_syndrome(out_syndrome),
    .clr_cnt(clr_cnt), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int n_out = 0;
  logic [REC_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int pos_of[DW] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  function automatic logic [PW-1:0] m_syn(input logic [CW-1:0] w);
    int s = 0;
    for (int i = 1; i < CW; i++) if (w[i]) s = s ^ i;
    return s[PW-1:0];
  endfunction

  function automatic logic [CW-1:0] m_encode(input logic [DW-1:0] d);
    logic [CW-1:0] cw = '0;
    logic [PW-1:0] s;
    for (int k = 0; k < DW; k++) cw[pos_of[k]] = d[k];
    s = m_syn(cw);
    cw[1] = s[0]; cw[2] = s[1]; cw[4] = s[2]; cw[8] = s[3];
    cw[0] = ^cw;
    return cw;
  endfunction

  function automatic logic [REC_W-1:0] model(input logic m, input logic [CW-1:0] w);
    logic [PW-1:0] s;
    logic p;
    logic [1:0] st;
    logic [CW-1:0] fixed;
    logic [DW-1:0] d;
    if (!m) return {1'b0, m_encode(w[DW-1:0]), 2'b00, 4'h0};
    s = m_syn(w);
    p = ^w;
    fixed = w;
    if (s == 0 && !p) st = 2'b00;
    else if (p) begin
      fixed[s] = ~fixed[s];
      st = 2'b01;
    end else st = 2'b10;
    for (int k = 0; k < DW; k++) d[k] = fixed[pos_of[k]];
    return {1'b1, 5'b0, d, st, s};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  int m_corr = 0;
  int m_uncorr = 0;
  logic held = 1'b0;
  logic [REC_W-1:0] held_val;

  always @(negedge clk) begin
    logic [REC_W-1:0] cur;
    logic [REC_W-1:0] e;
    logic inc_c;
    logic inc_u;
    cur = {out_mode, out_word, out_status, out_syndrome};
    inc_c = 1'b0;
    inc_u = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      m_corr = 0;
      m_uncorr = 0;
      held = 1'b0;
    end else begin
      check("corr_cnt", corr_cnt, m_corr);
      check("uncorr_cnt", uncorr_cnt, m_uncorr);
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", cur, held_val);
      end
      held = out_valid && !out_ready;
      held_val = cur;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", cur, 0);
        else begin
          e = exp_q.pop_front();
          n_out++;
          check("out_rec", cur, e);
          inc_c = e[REC_W-1] && e[5:4] == 2'b01;
          inc_u = e[REC_W-1] && e[5:4] == 2'b10;
        end
      end
      m_corr   = clr_cnt ? 0 : (inc_c && m_corr < 3) ? m_corr + 1 : m_corr;
      m_uncorr = clr_cnt ? 0 : (inc_u && m_uncorr < 3) ? m_uncorr + 1 : m_uncorr;
      if (in_valid && in_ready) exp_q.push_back(model(in_mode, in_word));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1. The task returns at posedge+1 just after the accepting edge.
  task automatic send(input logic m, input logic [CW-1:0] w);
    int t = 0;
    in_valid = 1'b1;
    in_mode = m;
    in_word = w;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("send_timeout", t, 0);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 200) begin
      step();
      t++;
    end
    check("drain_timeout", t < 200, 1);
  endtask

  typedef struct {
    logic          mode;
    logic [CW-1:0] word;
    logic [CW-1:0] exp_word;
    logic [1:0]    exp_st;
    logic [PW-1:0] exp_syn;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int t;
    int n0;
    int stuck;
    logic [CW-1:0] cw;
    logic [DW-1:0] d;
    logic m;
    int b1;
    int b2;
    int nf;
    logic done;

    vecs[0] = '{1'b0, 16'h0000, 16'h0000, 2'b00, 4'h0};
    vecs[1] = '{1'b0, 16'h07FF, 16'hFFFF, 2'b00, 4'h0};
    vecs[2] = '{1'b1, 16'hFFFF, 16'h07FF, 2'b00, 4'h0};
    vecs[3] = '{1'b1, 16'hFFBF, 16'h07FF, 2'b01, 4'h6};
    vecs[4] = '{1'b1, 16'hFFFE, 16'h07FF, 2'b01, 4'h0};
    vecs[5] = '{1'b1, 16'hFFFC, 16'h07FF, 2'b10, 4'h1};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_word", out_word, 0);
    check("rst_out_status", out_status, 0);
    check("rst_out_syn", out_syndrome, 0);
    check("rst_corr", corr_cnt, 0);
    check("rst_uncorr", uncorr_cnt, 0);

    // two-cycle latency
    step();
    send(1'b0, 16'h0000);
    @(negedge clk);
    check("lat_early", out_valid, 0);
    @(negedge clk);
    check("lat_valid", out_valid, 1);
    check("lat_word", out_word, 16'h0000);
    step();

    // table vectors
    for (int v = 0; v < 6; v++) begin
      send(vecs[v].mode, vecs[v].word);
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 10) begin
        @(negedge clk);
        t++;
      end
      check($sformatf("vec%0d_valid", v), out_valid, 1);
      check($sformatf("vec%0d_word", v), out_word, vecs[v].exp_word);
      check($sformatf("vec%0d_status", v), out_status, vecs[v].exp_st);
      check($sformatf("vec%0d_syn", v), out_syndrome, vecs[v].exp_syn);
      step();
    end
    step();
    check("tbl_corr_cnt", corr_cnt, 2);
    check("tbl_uncorr_cnt", uncorr_cnt, 1);

    // back-to-back encode followed by decode on consecutive cycles
    send(1'b0, 16'h07FF);
    send(1'b1, 16'hFFFF);
    @(negedge clk);
    check("b2b_v0", out_valid, 1);
    check("b2b_w0", out_word, 16'hFFFF);
    check("b2b_m0", out_mode, 0);
    @(negedge clk);
    check("b2b_v1", out_valid, 1);
    check("b2b_w1", out_word, 16'h07FF);
    check("b2b_m1", out_mode, 1);
    check("b2b_s1", out_status, 0);
    step();
    drain();

    // backpressure: two accepted, the third waits
    n0 = n_out;
    out_ready = 1'b0;
    send(1'b0, 16'h0123);
    send(1'b1, 16'hFFBF);
    in_valid = 1'b1;
    in_mode = 1'b0;
    in_word = 16'h0456;
    stuck = 0;
    repeat (4) begin
      @(negedge clk);
      if (!in_ready) stuck++;
    end
    check("bp_in_ready_low", stuck, 4);
    check("bp_out_valid", out_valid, 1);
    step();
    out_ready = 1'b1;
    send(1'b0, 16'h0456);
    drain();
    check("bp_all_out", n_out - n0, 3);

    // saturation of corr_cnt
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check("clr_idle", corr_cnt, 0);
    repeat (5) send(1'b1, 16'hFFBF);
    drain();
    check("sat_corr", corr_cnt, 3);

    // clr_cnt wins over a simultaneous status-01 increment
    out_ready = 1'b0;
    send(1'b1, 16'hFFBF);
    step();
    check("clrwin_pending", out_valid, 1);
    clr_cnt = 1'b1;
    out_ready = 1'b1;
    step();
    clr_cnt = 1'b0;
    check("clrwin_corr", corr_cnt, 0);
    drain();

    // random traffic with random backpressure and occasional clears
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          m = $urandom_range(0, 1);
          d = $urandom;
          cw = $urandom;
          if (m) begin
            cw = m_encode(d);
            nf = $urandom_range(0, 2);
            b1 = $urandom_range(0, CW - 1);
            b2 = (b1 + $urandom_range(1, CW - 1)) % CW;
            if (nf >= 1) cw[b1] = ~cw[b1];
            if (nf == 2) cw[b2] = ~cw[b2];
          end
          clr_cnt = ($urandom_range(0, 19) == 0);
          send(m, cw);
          clr_cnt = 1'b0;
          if ($urandom_range(0, 3) == 0) step();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          step();
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // asynchronous reset mid-stream
    send(1'b1, 16'hFFBF);
    send(1'b1, 16'hFFFC);
    drain();
    out_ready = 1'b0;
    send(1'b0, 16'h0001);
    send(1'b0, 16'h0002);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_corr", corr_cnt, 0);
    check("arst_uncorr", uncorr_cnt, 0);
    check("arst_in_ready", in_ready, 1);
    step();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    n0 = n_out;
    repeat (5) step();
    check("arst_no_out", out_valid, 0);
    check("arst_none_emitted", n_out - n0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
